rotary_value_ctrl: RTL

- Downstream consumer of the rotary decoder.
- Turns its rot_cw/rot_ccw detent indications into a bounded, user-adjustable value. Fast spinning produces larger steps (acceleration).
- Drives the value to display/register logic, plus a one-cycle change strobe.

---
 rtl/rotary_pkg.sv | 12 +
 rtl/detent_timer.sv | 45 ++++
 rtl/rotary_value_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rotary_pkg.sv
// Shared types for the rotary value controller: detent speed classes.
package rotary_pkg;

  localparam int unsigned SPEED_W = 2;

  typedef enum logic [SPEED_W-1:0] {
    SPEED_SLOW = 2'd0,
    SPEED_MED  = 2'd1,
    SPEED_FAST = 2'd2
  } speed_t;

endpackage

// File: rtl/detent_timer.sv
// Saturating count of cycles since the last accepted detent, classified into a speed class.
// Only instantiated when ROTARY_VALUE_ACCEL_EN is defined.
module detent_timer
  import rotary_pkg::*;
#(
  parameter int unsigned FAST_TICKS = 500000,
  parameter int unsigned MED_TICKS  = 2000000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_restart,
  input  logic   i_preset,
  output speed_t o_class
);

  localparam int unsigned     CNT_W    = $clog2(MED_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MED_TICKS);
  localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(FAST_TICKS);

  logic [CNT_W-1:0] r_cnt;

  // Reset and preset park the counter at saturation so the next detent is slow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_MAX;
    end else if (i_preset) begin
      r_cnt <= CNT_MAX;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    if (r_cnt < CNT_FAST) begin
      o_class = SPEED_FAST;
    end else if (r_cnt < CNT_MAX) begin
      o_class = SPEED_MED;
    end else begin
      o_class = SPEED_SLOW;
    end
  end

endmodule

// File: rtl/rotary_value_ctrl.sv
// Bounded, user-adjustable value driven by rotary detents, with change strobe.
// Acceleration (speed-dependent step) is built only when ROTARY_VALUE_ACCEL_EN is defined.
module rotary_value_ctrl
  import rotary_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MIN_VAL    = 0,
  parameter int unsigned MAX_VAL    = 1000,
  parameter int unsigned INIT_VAL   = 0,
  parameter int unsigned FAST_TICKS = 500000,
  parameter int unsigned MED_TICKS  = 2000000,
  parameter int unsigned STEP_MED   = 4,
  parameter int unsigned STEP_FAST  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rot_cw,
  input  logic               i_rot_ccw,
  input  logic               i_clear,
  output logic [WIDTH-1:0]   o_value,
  output logic               o_changed,
  output logic [SPEED_W-1:0] o_speed,
  output logic               o_at_min,
  output logic               o_at_max
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);

  logic             r_cw_q;
  logic             r_ccw_q;
  logic [WIDTH-1:0] r_value;
  logic             r_changed;
  speed_t           r_speed;

  logic             w_cw_ev;
  logic             w_ccw_ev;
  logic             w_accept;
  speed_t           w_class;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_floor;
  logic [WIDTH-1:0] w_next;

  assign w_cw_ev  = i_rot_cw & ~r_cw_q;
  assign w_ccw_ev = i_rot_ccw & ~r_ccw_q;
  // Opposite detents in one cycle cancel; clear wins over any detent.
  assign w_accept = (w_cw_ev ^ w_ccw_ev) & ~i_clear;

`ifdef ROTARY_VALUE_ACCEL_EN
  detent_timer #(
    .FAST_TICKS (FAST_TICKS),
    .MED_TICKS  (MED_TICKS)
  ) u_detent_timer (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_accept),
    .i_preset  (i_clear),
    .o_class   (w_class)
  );

  always_comb begin
    unique case (w_class)
      SPEED_FAST: w_step = (WIDTH+1)'(STEP_FAST);
      SPEED_MED:  w_step = (WIDTH+1)'(STEP_MED);
      default:    w_step = (WIDTH+1)'(1);
    endcase
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{FAST_TICKS, MED_TICKS, STEP_MED, STEP_FAST};
  assign w_class      = SPEED_SLOW;
  assign w_step       = (WIDTH+1)'(1);
`endif

  // One extra bit keeps the add free of wrap before clamping.
  assign w_sum   = {1'b0, r_value} + w_step;
  assign w_floor = MIN_X + w_step;

  always_comb begin
    w_next = r_value;
    if (w_cw_ev) begin
      w_next = (w_sum > MAX_X) ? MAX_V : w_sum[WIDTH-1:0];
    end else if ({1'b0, r_value} < w_floor) begin
      w_next = MIN_V;
    end else begin
      w_next = r_value - w_step[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cw_q    <= 1'b0;
      r_ccw_q   <= 1'b0;
      r_value   <= INIT_V;
      r_changed <= 1'b0;
      r_speed   <= SPEED_SLOW;
    end else begin
      r_cw_q    <= i_rot_cw;
      r_ccw_q   <= i_rot_ccw;
      r_changed <= 1'b0;
      if (i_clear) begin
        r_value   <= INIT_V;
        r_speed   <= SPEED_SLOW;
        r_changed <= (r_value != INIT_V);
      end else if (w_accept) begin
        r_value   <= w_next;
        r_speed   <= w_class;
        r_changed <= (w_next != r_value);
      end
    end
  end

  assign o_value   = r_value;
  assign o_changed = r_changed;
  assign o_speed   = r_speed;
  assign o_at_min  = (r_value == MIN_V);
  assign o_at_max  = (r_value == MAX_V);

endmodule
